mac16_accum: RTL and testbench

//  Sequential multiply-accumulate stage downstream of the 16x16 unsigned wallace16 multiplier.

---
 rtl/mac16_accum_pkg.sv | 24 ++
 rtl/mac16_accum_wallace16.sv | 66 ++++++
 rtl/mac16_accum.sv | 157 +++++++++++++++
 tb/tb_mac16_accum.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mac16_accum_pkg.sv
// -----------------------------------------------------------------------------
// mac16_accum_pkg
//   Shared definitions for the mac16_accum multiply-accumulate block:
//   FSM state encoding, default parameter values and the product width.
//   No ports (package).
// -----------------------------------------------------------------------------
package mac16_accum_pkg;

    // FSM state encoding (IDLE=0, RUN=1, DONE=2)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Default accumulator width (must be >= PROD_W) and run-length width
    localparam int ACC_W_DEF = 40;
    localparam int LEN_W_DEF = 8;

    // Operand and product widths of the wallace16 multiplier
    localparam int OPND_W = 16;
    localparam int PROD_W = 32;

endpackage : mac16_accum_pkg

// File: rtl/mac16_accum_wallace16.sv
// -----------------------------------------------------------------------------
// wallace16
//   Combinational 16x16 unsigned multiplier built as a Wallace tree: sixteen
//   partial-product rows are reduced with 3:2 carry-save compressors until two
//   rows remain, which are then summed by a single carry-propagate adder.
// Ports
//   A    in   16  unsigned multiplicand
//   B    in   16  unsigned multiplier
//   out  out  32  unsigned product A*B
// -----------------------------------------------------------------------------
module wallace16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] out
);

    // 16 rows reduce 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 in six CSA layers
    localparam int NUM_ROWS   = 16;
    localparam int NUM_LAYERS = 6;

    function automatic logic [31:0] wallace_mul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] rows [NUM_ROWS];
        logic [31:0] nxt  [NUM_ROWS];
        int          n;
        int          m;
        int          rem;
        for (int i = 0; i < NUM_ROWS; i++) begin
            rows[i] = {16'b0, x & {16{y[i]}}} << i;
        end
        n = NUM_ROWS;
        for (int s = 0; s < NUM_LAYERS; s++) begin
            m = 0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                nxt[i] = '0;
            end
            // Each complete group of three rows becomes a sum row and a
            // shifted carry row. Carries out of bit 31 are dropped; the
            // true product always fits in 32 bits.
            for (int g = 0; g < NUM_ROWS / 3; g++) begin
                if (3 * g + 2 < n) begin
                    nxt[m]     = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
                    nxt[m + 1] = ((rows[3*g]   & rows[3*g+1]) |
                                  (rows[3*g]   & rows[3*g+2]) |
                                  (rows[3*g+1] & rows[3*g+2])) << 1;
                    m = m + 2;
                end
            end
            // Leftover rows (0..2) pass straight through to the next layer
            rem = 3 * (n / 3);
            for (int k = 0; k < 2; k++) begin
                if (rem + k < n) begin
                    nxt[m] = rows[rem + k];
                    m = m + 1;
                end
            end
            rows = nxt;
            n    = m;
        end
        return rows[0] + rows[1];
    endfunction

    always_comb begin
        out = wallace_mul(A, B);
    end

endmodule : wallace16

// File: rtl/mac16_accum.sv
// -----------------------------------------------------------------------------
// mac16_accum
//   Sequential multiply-accumulate stage. A run of `len` operand pairs arrives
//   on a valid/ready stream; each pair is multiplied by wallace16 and the
//   32-bit products are summed into an ACC_W-bit accumulator. One result per
//   run is presented on a valid/ready output together with a sticky carry-out
//   flag. Three-edge pipeline: accept -> multiply -> accumulate; never stalls.
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin a run (sampled only in IDLE)
//   len        in   LEN_W  products in the run, captured with start
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      operand pair accepted when in_valid is also high
//   a, b       in   16     unsigned operands
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer accepts result
//   acc_out    out  ACC_W  accumulated sum, modulo 2**ACC_W
//   overflow   out  1      some add in this run carried out of ACC_W
//   busy       out  1      block not in IDLE
// -----------------------------------------------------------------------------
module mac16_accum
    import mac16_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    output logic              busy
);

    state_e              state_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    issued_q;
    logic [LEN_W-1:0]    done_q;
    logic [OPND_W-1:0]   a_q;
    logic [OPND_W-1:0]   b_q;
    logic [PROD_W-1:0]   p_d;
    logic [PROD_W-1:0]   p_q;
    logic [2:1]          vld_pipe_q;   // [1]: operands registered, [2]: product registered
    logic [ACC_W-1:0]    acc_q;
    logic                ovf_q;
    logic                out_valid_q;
    logic                busy_q;

    logic                accept;
    logic [ACC_W:0]      acc_sum_d;    // MSB is the carry out of the accumulator
    logic                last_add;

    assign in_ready  = (state_q == S_RUN) && (issued_q < len_q);
    assign accept    = in_valid && in_ready;
    assign acc_sum_d = {1'b0, acc_q} + (ACC_W+1)'(p_q);
    assign last_add  = vld_pipe_q[2] && (done_q == len_q - LEN_W'(1));

    // Multiplier sits between the operand and product registers
    wallace16 u_mul (
        .A   (a_q),
        .B   (b_q),
        .out (p_d)
    );

    // Operand / product pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            vld_pipe_q <= '0;
        end else begin
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (vld_pipe_q[1]) begin
                p_q <= p_d;
            end
            vld_pipe_q <= {vld_pipe_q[1], accept};
        end
    end

    // Control FSM, counters and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            done_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        issued_q <= '0;
                        done_q   <= '0;
                        acc_q    <= '0;
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        // An empty run goes straight to a zero result
                        if (len == '0) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        issued_q <= issued_q + LEN_W'(1);
                    end
                    if (vld_pipe_q[2]) begin
                        acc_q  <= acc_sum_d[ACC_W-1:0];
                        ovf_q  <= ovf_q | acc_sum_d[ACC_W];
                        done_q <= done_q + LEN_W'(1);
                        if (last_add) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule : mac16_accum

// File: tb/tb_mac16_accum.sv
// -----------------------------------------------------------------------------
// tb_mac16_accum
//   Directed bench for mac16_accum. Two instances share the input stimulus:
//   one with ACC_W=40 and one with ACC_W=32 (for the wrap/overflow case).
// -----------------------------------------------------------------------------
module tb_mac16_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_ready;

    logic        in_ready,  out_valid,  overflow,  busy;
    logic [39:0] acc_out;
    logic        in_ready32, out_valid32, overflow32, busy32;
    logic [31:0] acc_out32;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mac16_accum #(.ACC_W(40), .LEN_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .overflow(overflow), .busy(busy)
    );

    mac16_accum #(.ACC_W(32), .LEN_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready32), .a(a), .b(b),
        .out_valid(out_valid32), .out_ready(out_ready), .acc_out(acc_out32),
        .overflow(overflow32), .busy(busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair; it must be accepted on the next edge
    task automatic beat(input string tag, input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1;
        a = x;
        b = y;
        chk(tag, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, out_valid, 1'b1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ovalid"}, out_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;

        // 1: asynchronous reset asserted mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_acc",       acc_out,   40'd0);
        chk("rst_ovf",       overflow,  1'b0);
        chk("rst_busy",      busy,      1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 2: three back-to-back beats, 12+30+56 = 98
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0; len = 8'd77;
        chk("t2_busy", busy, 1'b1);
        beat("t2_b0", 16'd3, 16'd4);
        beat("t2_b1", 16'd5, 16'd6);
        beat("t2_b2", 16'd7, 16'd8);
        chk("t2_lat0",     out_valid, 1'b0);
        chk("t2_inr_full", in_ready,  1'b0);
        tick();
        chk("t2_lat1", out_valid, 1'b0);
        tick();
        chk("t2_lat2", out_valid, 1'b1);
        chk("t2_acc",  acc_out,   40'd98);
        chk("t2_ovf",  overflow,  1'b0);
        chk("t2_acc32", acc_out32, 32'd98);
        handshake("t2_hs");

        // 3: 2 x 0xFFFF*0xFFFF, wraps in the 32-bit instance only
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        beat("t3_b0", 16'hFFFF, 16'hFFFF);
        beat("t3_b1", 16'hFFFF, 16'hFFFF);
        wait_done("t3_done");
        chk("t3_acc40", acc_out,    40'h1_FFFC_0002);
        chk("t3_ovf40", overflow,   1'b0);
        chk("t3_acc32", acc_out32,  32'hFFFC_0002);
        chk("t3_ovf32", overflow32, 1'b1);
        handshake("t3_hs");

        // 4: gaps on the input, out_ready held off, start ignored in DONE
        //    2 + 12 + 100 + 20000 = 20114
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        beat("t4_b0", 16'd1, 16'd2);
        a = 16'hFFFF; b = 16'hFFFF;
        tick();
        beat("t4_b1", 16'd3, 16'd4);
        a = 16'h1234; b = 16'h5678;
        tick(); tick();
        beat("t4_b2", 16'd10, 16'd10);
        beat("t4_b3", 16'd100, 16'd200);
        wait_done("t4_done");
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 8'd7;
            tick();
            chk("t4_hold_valid", out_valid, 1'b1);
            chk("t4_hold_acc",   acc_out,   40'd20114);
            chk("t4_hold_inr",   in_ready,  1'b0);
        end
        start = 1'b0;
        chk("t4_ovf", overflow, 1'b0);
        handshake("t4_hs");

        // 5: empty run yields a zero result on the next cycle
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_acc",   acc_out,   40'd0);
        chk("t5_ovf",   overflow,  1'b0);
        chk("t5_busy",  busy,      1'b1);
        handshake("t5_hs");

        // 6: reset aborts a partial run; a fresh run then works
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        beat("t6_b0", 16'd50, 16'd50);
        beat("t6_b1", 16'd60, 16'd60);
        tick();
        chk("t6_partial_acc", acc_out, 40'd2500);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_inr",   in_ready,  1'b0);
        chk("t6_rst_acc",   acc_out,   40'd0);
        chk("t6_rst_ovf",   overflow,  1'b0);
        chk("t6_rst_busy",  busy,      1'b0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("t6_no_result", out_valid, 1'b0);
        chk("t6_idle_acc",  acc_out,   40'd0);
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        beat("t6_b2", 16'd2, 16'd9);
        wait_done("t6_done");
        chk("t6_acc", acc_out,  40'd18);
        chk("t6_ovf", overflow, 1'b0);
        handshake("t6_hs");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_mac16_accum
